// File: rtl/wb_ctrl_pkg.sv
// Shared sizing defines and types for the writeback controller.
`ifndef WB_CTRL_DEFINES
`define WB_CTRL_DEFINES
`define NUM_REG        32
`define REG_ADDR_WIDTH 5
`define REG_WIDTH      32
`define SB_CNT_WIDTH   2
`endif

package wb_ctrl_pkg;
  localparam int SB_CNT_WIDTH = `SB_CNT_WIDTH;

  // Which source won the most recent two-way conflict.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, issue back-pressure and hazard query.
module wb_scoreboard
  import wb_ctrl_pkg::*;
#(
  parameter int NUM_REG        = `NUM_REG,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = SB_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      issue_ready,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rd,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rs2,
  output logic                      busy_rs1,
  output logic                      busy_rs2,
  output logic                      sb_err
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_REG-1:0][CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] issue_cnt, rs1_cnt, rs2_cnt;
  logic                 issue_fire, underflow;

  // Index 0 is never looked up, so it always reads as zero (never busy).
  always_comb begin
    issue_cnt = '0;
    rs1_cnt   = '0;
    rs2_cnt   = '0;
    for (int i = 1; i < NUM_REG; i++) begin
      if (issue_rd == REG_ADDR_WIDTH'(i)) issue_cnt = cnt[i];
      if (addr_rs1 == REG_ADDR_WIDTH'(i)) rs1_cnt   = cnt[i];
      if (addr_rs2 == REG_ADDR_WIDTH'(i)) rs2_cnt   = cnt[i];
    end
  end

  assign issue_ready = (issue_cnt != CNT_MAX);
  assign busy_rs1    = (rs1_cnt != '0);
  assign busy_rs2    = (rs2_cnt != '0);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  // Same-edge reserve and retire on one register cancel out.
  always_comb begin
    cnt_nxt   = cnt;
    underflow = 1'b0;
    for (int i = 1; i < NUM_REG; i++) begin
      logic inc, dec;
      inc = issue_fire && (issue_rd == REG_ADDR_WIDTH'(i));
      dec = wr_en && (addr_rd == REG_ADDR_WIDTH'(i));
      if (inc && !dec) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt[i] == '0) underflow = 1'b1;
        else              cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sb_err <= sb_err | underflow;
    end
  end
endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: round-robin ALU/LSU result arbitration, registered
// register-file write port, and the pending-write scoreboard.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int NUM_REG        = `NUM_REG,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int REG_WIDTH      = `REG_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]      alu_data,
  output logic                      alu_ready,
  input  logic                      lsu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [REG_WIDTH-1:0]      lsu_data,
  output logic                      lsu_ready,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd,
  output logic [REG_WIDTH-1:0]      data_rd,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rs2,
  output logic                      busy_rs1,
  output logic                      busy_rs2,
  output logic                      sb_err
);
  grant_e                    last_grant;
  logic                      conflict, accept;
  logic [REG_ADDR_WIDTH-1:0] sel_rd;
  logic [REG_WIDTH-1:0]      sel_data;

  // A lone requester always wins; on a conflict the one not granted last wins.
  assign conflict  = alu_valid && lsu_valid;
  assign alu_ready = alu_valid && (!lsu_valid || (last_grant == GRANT_LSU));
  assign lsu_ready = lsu_valid && (!alu_valid || (last_grant == GRANT_ALU));
  assign accept    = alu_ready || lsu_ready;
  assign sel_rd    = lsu_ready ? lsu_rd   : alu_rd;
  assign sel_data  = lsu_ready ? lsu_data : alu_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      last_grant <= GRANT_ALU;
    else if (conflict) last_grant <= lsu_ready ? GRANT_LSU : GRANT_ALU;
  end

  // Results to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      addr_rd <= '0;
      data_rd <= '0;
    end else begin
      wr_en <= accept && (sel_rd != '0);
      if (accept) begin
        addr_rd <= sel_rd;
        data_rd <= sel_data;
      end
    end
  end

  wb_scoreboard #(
    .NUM_REG        (NUM_REG),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .CNT_WIDTH      (SB_CNT_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wr_en       (wr_en),
    .addr_rd     (addr_rd),
    .addr_rs1    (addr_rs1),
    .addr_rs2    (addr_rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .sb_err      (sb_err)
  );
endmodule

// File: tb/tb_wb_ctrl.sv
// Directed and randomized bench for wb_ctrl against a counting reference model.
module tb_wb_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, addr_rs1, addr_rs2;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, wr_en, issue_ready, busy_rs1, busy_rs2, sb_err;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;

  wb_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .wr_en(wr_en), .addr_rd(addr_rd), .data_rd(data_rd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;

  // Reference model: outstanding-write counts, who won the last conflict,
  // the write currently presented, and the sticky error.
  int          m_cnt [32];
  bit          m_last_lsu;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  bit          got_ar, got_lr, exp_ar, exp_lr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last_lsu = 1'b0;
    m_wr = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One cycle: inputs already driven after a negedge. Check combinational
  // outputs, advance the model across the posedge, check registered outputs.
  task automatic step();
    int          d [32];
    bit          exp_ir, n_wr;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    #1;
    exp_ar = alu_valid && (!lsu_valid || m_last_lsu);
    exp_lr = lsu_valid && (!alu_valid || !m_last_lsu);
    exp_ir = (issue_rd == 0) || (m_cnt[issue_rd] < 3);
    got_ar = alu_ready; got_lr = lsu_ready;
    chk("alu_ready", alu_ready, exp_ar);
    chk("lsu_ready", lsu_ready, exp_lr);
    chk("issue_ready", issue_ready, exp_ir);
    chk("busy_rs1", busy_rs1, m_cnt[addr_rs1] != 0);
    chk("busy_rs2", busy_rs2, m_cnt[addr_rs2] != 0);
    foreach (d[i]) d[i] = 0;
    if (issue_valid && exp_ir && issue_rd != 0) d[issue_rd] += 1;
    if (m_wr) begin
      if (m_cnt[m_addr] == 0 && d[m_addr] == 0) m_err = 1'b1;
      else d[m_addr] -= 1;
    end
    if (alu_valid && lsu_valid) m_last_lsu = exp_lr;
    w_rd   = exp_lr ? lsu_rd : alu_rd;
    w_data = exp_lr ? lsu_data : alu_data;
    n_wr   = (exp_ar || exp_lr) && (w_rd != 0);
    @(posedge clk);
    foreach (m_cnt[i]) m_cnt[i] += d[i];
    m_wr = n_wr;
    if (exp_ar || exp_lr) begin m_addr = w_rd; m_data = w_data; end
    @(negedge clk);
    chk("wr_en", wr_en, m_wr);
    chk("sb_err", sb_err, m_err);
    if (m_wr) begin
      chk("addr_rd", addr_rd, m_addr);
      chk("data_rd", data_rd, m_data);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    addr_rs1 = 7; addr_rs2 = 5;
    model_reset();
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr_rd", addr_rd, 0);
    chk("rst_data_rd", data_rd, 0);
    chk("rst_sb_err", sb_err, 0);
    chk("rst_busy", busy_rs1, 0);
    @(negedge clk); reset_n = 1'b1;

    // Single ALU result.
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    issue_valid = 1; issue_rd = 5;
    step();
    chk("alu_only_ready", got_ar, 1);
    chk("alu_only_wr_en", wr_en, 1);
    chk("alu_only_addr", addr_rd, 5);
    chk("alu_only_data", data_rd, 32'hDEADBEEF);
    idle_inputs();
    step();

    // Conflict alternation from reset: LSU, ALU, LSU, ALU.
    do_reset();
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA1A1_0003;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hB2B2_0004;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_lsu_grant", got_lr, (k % 2) == 0);
      chk("rr_wr_en", wr_en, 1);
      chk("rr_addr", addr_rd, (k % 2) == 0 ? 4 : 3);
    end
    idle_inputs();
    step();

    // Saturating reservations on rd=7.
    do_reset();
    addr_rs1 = 7;
    issue_valid = 1; issue_rd = 7;
    repeat (3) step();
    #1;
    chk("sat_issue_ready", issue_ready, 0);
    chk("sat_busy", busy_rs1, 1);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h7;
    step();
    alu_valid = 0;
    step();
    chk("sat_ready_again", issue_ready, 1);
    alu_valid = 1;
    repeat (2) step();
    alu_valid = 0;
    step();
    chk("sat_busy_clear", busy_rs1, 0);
    chk("sat_no_err", sb_err, 0);

    // Result to x0.
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
    step();
    chk("x0_ready", got_ar, 1);
    chk("x0_wr_en", wr_en, 0);
    alu_valid = 0;
    step();
    chk("x0_no_err", sb_err, 0);

    // Same-edge reserve/retire on rd=9, then underflow.
    do_reset();
    addr_rs1 = 9;
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    step();
    alu_valid = 0; issue_valid = 1;
    step();
    chk("cancel_busy", busy_rs1, 1);
    chk("cancel_no_err", sb_err, 0);
    issue_valid = 0;
    alu_valid = 1;
    step();
    step();
    alu_valid = 0;
    step();
    chk("uflow_err", sb_err, 1);
    chk("uflow_busy", busy_rs1, 0);
    repeat (2) step();
    chk("uflow_sticky", sb_err, 1);

    // Reset right after an accepted write.
    do_reset();
    addr_rs1 = 6;
    issue_valid = 1; issue_rd = 6;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    step();
    chk("pre_rst_wr_en", wr_en, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_err", sb_err, 0);
    for (int r = 0; r < 32; r++) begin
      addr_rs1 = 5'(r);
      #1;
      chk("async_rst_busy", busy_rs1, 0);
    end
    idle_inputs();
    model_reset();
    @(negedge clk); reset_n = 1'b1;

    // Randomized traffic with source hold until acceptance.
    got_ar = 1; got_lr = 1;
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid || got_ar) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!lsu_valid || got_lr) begin
        lsu_valid = 1'($urandom_range(0, 1));
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      addr_rs1    = 5'($urandom_range(0, 7));
      addr_rs2    = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
